// File: rtl/alu_pkg.sv
// Shared definitions for the execution-stage ALU: operation codes, FSM states
// and small decode helpers used by the ALU and the control decoder.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_MUL = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
            ALU_SLT, ALU_XOR, ALU_MUL: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the decode stage, the ALU and writeback.
// master = requester/consumer side, slave = the ALU.
interface alu_exec_unit_if #(
    parameter int WIDTH = 24
);
    logic             InValid;
    logic             InReady;
    logic [3:0]       ALUContr;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;
    logic             IllegalOp;

    modport master (
        output InValid, ALUContr, OpA, OpB, OutReady,
        input  InReady, OutValid, Result, Zero, Overflow, IllegalOp
    );

    modport slave (
        input  InValid, ALUContr, OpA, OpB, OutReady,
        output InReady, OutValid, Result, Zero, Overflow, IllegalOp
    );
endinterface

// File: rtl/alu_comb_core.sv
// Combinational single-cycle datapath: AND/OR/XOR/ADD/SUB/SLT with signed
// overflow detection. MUL is handled by the iterative unit in the top level.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             slt_s;

    assign sum_s  = a_i + b_i;
    assign diff_s = a_i + ~b_i + {{(WIDTH-1){1'b0}}, 1'b1};
    assign slt_s  = ($signed(a_i) < $signed(b_i));

    // Operation select; overflow only meaningful for ADD/SUB
    always_comb begin
        result_o   = {WIDTH{1'b0}};
        overflow_o = 1'b0;
        illegal_o  = 1'b0;
        case (op_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_ADD: begin
                result_o   = sum_s;
                overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                             (sum_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                result_o   = diff_s;
                overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                             (diff_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_MUL: result_o = {WIDTH{1'b0}};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: valid/ready wrapped single-cycle datapath plus a
// fixed-latency shift-add multiplier, with registered result and flags.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic           Clock,
    input  logic           Reset,
    alu_exec_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    alu_state_e        state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  result_q;
    logic              zero_q;
    logic              overflow_q;
    logic              illegal_q;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;
    logic [CNT_W-1:0]  cnt_q;

    logic [WIDTH-1:0]  core_result_s;
    logic              core_overflow_s;
    logic              core_illegal_s;
    logic              accept_s;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op_i       (bus.ALUContr),
        .a_i        (bus.OpA),
        .b_i        (bus.OpB),
        .result_o   (core_result_s),
        .overflow_o (core_overflow_s),
        .illegal_o  (core_illegal_s)
    );

    assign accept_s = bus.InValid && in_ready_q && (state_q == ST_IDLE);

    // One shift-add step of the multiplier
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Control FSM, multiplier state and registered outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            mcand_q     <= {WIDTH{1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept_s) begin
                        in_ready_q <= 1'b0;
                        if (is_mul_op(bus.ALUContr)) begin
                            mcand_q  <= bus.OpA;
                            mplier_q <= bus.OpB;
                            acc_q    <= {WIDTH{1'b0}};
                            cnt_q    <= {CNT_W{1'b0}};
                            state_q  <= ST_MUL;
                        end else begin
                            result_q    <= core_result_s;
                            zero_q      <= (core_result_s == {WIDTH{1'b0}});
                            overflow_q  <= core_overflow_s;
                            illegal_q   <= core_illegal_s;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    in_ready_q <= 1'b0;
                    acc_q      <= acc_d;
                    mcand_q    <= mcand_q << 1;
                    mplier_q   <= mplier_q >> 1;
                    cnt_q      <= cnt_q + CNT_W'(1);
                    // Fixed WIDTH iterations regardless of multiplier value
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q    <= acc_d;
                        zero_q      <= (acc_d == {WIDTH{1'b0}});
                        overflow_q  <= 1'b0;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.OutReady) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InReady   = in_ready_q;
    assign bus.OutValid  = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = overflow_q;
    assign bus.IllegalOp = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int WIDTH = 24;

    logic Clock = 1'b0;
    logic Reset;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sext(input logic [23:0] v);
        longint r;
        r = longint'(v);
        if (r >= 64'sd8388608) r = r - 64'sd16777216;
        return r;
    endfunction

    // Reference: plain integer arithmetic on signed/unsigned interpretations
    task automatic model(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                         output logic [23:0] r, output logic ovf, output logic ill, output int lat);
        longint sa, sb, t;
        sa = sext(a);
        sb = sext(b);
        ovf = 1'b0;
        ill = 1'b0;
        lat = 1;
        r = 24'd0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0100: r = a ^ b;
            4'b0010: begin
                t = sa + sb;
                r = 24'(t);
                ovf = (t > 64'sd8388607) || (t < -64'sd8388608);
            end
            4'b1010: begin
                t = sa - sb;
                r = 24'(t);
                ovf = (t > 64'sd8388607) || (t < -64'sd8388608);
            end
            4'b1011: r = (sa < sb) ? 24'd1 : 24'd0;
            4'b0110: begin
                t = longint'(a) * longint'(b);
                r = 24'(t);
                lat = 25;
            end
            default: ill = 1'b1;
        endcase
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.InReady && n < 60) begin
            @(posedge Clock); #1;
            n++;
        end
        chk_val({tag, " in_ready"}, 32'(bus.InReady), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        logic [23:0] er;
        logic eo, ei, ir_seen;
        int el, lat;
        model(op, a, b, er, eo, ei, el);
        wait_ready(tag);
        bus.InValid  = 1'b1;
        bus.ALUContr = op;
        bus.OpA      = a;
        bus.OpB      = b;
        @(posedge Clock); #1;
        bus.InValid = 1'b0;
        lat = 1;
        ir_seen = 1'b0;
        while (!bus.OutValid && lat < 60) begin
            ir_seen |= bus.InReady;
            @(posedge Clock); #1;
            lat++;
        end
        ir_seen |= bus.InReady;
        chk_val({tag, " latency"}, 32'(lat), 32'(el));
        chk_val({tag, " result"}, 32'(bus.Result), 32'(er));
        chk_val({tag, " zero"}, 32'(bus.Zero), 32'(er == 24'd0));
        chk_val({tag, " overflow"}, 32'(bus.Overflow), 32'(eo));
        chk_val({tag, " illegal"}, 32'(bus.IllegalOp), 32'(ei));
        chk_val({tag, " busy_ready"}, 32'(ir_seen), 32'd0);
        bus.OutReady = 1'b1;
        @(posedge Clock); #1;
        bus.OutReady = 1'b0;
        chk_val({tag, " consumed"}, 32'(bus.OutValid), 32'd0);
    endtask

    initial begin
        logic [3:0] codes [8];
        logic [3:0] op;
        logic       seen;
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0100; codes[3] = 4'b0010;
        codes[4] = 4'b1010; codes[5] = 4'b1011; codes[6] = 4'b0110; codes[7] = 4'b1111;

        Reset        = 1'b0;
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b0;
        bus.ALUContr = 4'd0;
        bus.OpA      = 24'd0;
        bus.OpB      = 24'd0;
        #2;
        chk_val("rst in_ready", 32'(bus.InReady), 32'd0);
        chk_val("rst out_valid", 32'(bus.OutValid), 32'd0);
        chk_val("rst result", 32'(bus.Result), 32'd0);
        chk_val("rst flags", {29'd0, bus.Zero, bus.Overflow, bus.IllegalOp}, 32'd0);
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock); #1;
        chk_val("post_rst in_ready", 32'(bus.InReady), 32'd1);

        do_op("add_ovf", 4'b0010, 24'h7FFFFF, 24'h000001);
        do_op("sub_zero", 4'b1010, 24'd5, 24'd5);
        do_op("slt_neg", 4'b1011, 24'hFFFFFF, 24'h000001);
        do_op("mul_basic", 4'b0110, 24'd1000, 24'd3000);
        do_op("mul_trunc", 4'b0110, 24'h800000, 24'd2);
        do_op("mul_by0", 4'b0110, 24'h123456, 24'd0);
        do_op("illegal", 4'b1111, 24'h00ABCD, 24'h001234);
        do_op("sub_ovf", 4'b1010, 24'h800000, 24'h000001);

        // Stall: result must hold while a new request waits
        wait_ready("stall");
        bus.InValid  = 1'b1;
        bus.ALUContr = 4'b0000;
        bus.OpA      = 24'hF0F0F0;
        bus.OpB      = 24'h0FF0FF;
        @(posedge Clock); #1;
        bus.ALUContr = 4'b0100;
        bus.OpA      = 24'h123456;
        bus.OpB      = 24'h654321;
        for (int i = 0; i < 10; i++) begin
            chk_val("stall result", 32'(bus.Result), 32'h00F0F0);
            chk_val("stall hold", {30'd0, bus.OutValid, bus.InReady}, 32'd2);
            @(posedge Clock); #1;
        end
        bus.OutReady = 1'b1;
        @(posedge Clock); #1;
        bus.OutReady = 1'b0;
        do_op("after_stall", 4'b0100, 24'h123456, 24'h654321);

        // Reset in the middle of a multiply
        wait_ready("mulrst");
        bus.InValid  = 1'b1;
        bus.ALUContr = 4'b0110;
        bus.OpA      = 24'd777;
        bus.OpB      = 24'd999;
        @(posedge Clock); #1;
        bus.InValid = 1'b0;
        repeat (12) @(posedge Clock);
        #3 Reset = 1'b0;
        #1;
        chk_val("mulrst result", 32'(bus.Result), 32'd0);
        chk_val("mulrst ctrl", {30'd0, bus.OutValid, bus.InReady}, 32'd0);
        repeat (2) @(posedge Clock);
        #3 Reset = 1'b1;
        @(posedge Clock); #1;
        chk_val("mulrst in_ready", 32'(bus.InReady), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            seen |= bus.OutValid;
            @(posedge Clock); #1;
        end
        chk_val("mulrst no_stale", 32'(seen), 32'd0);

        for (int i = 0; i < 30; i++) begin
            op = codes[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
            do_op("rand", op, 24'($urandom), 24'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
